// File: rtl/icache_ctrl.sv
// ============================================================================
// icache_ctrl
// ----------------------------------------------------------------------------
// Instruction-cache controller placed directly in front of the I-cache SRAM.
// Accepts fetch requests from the CPU and drives the SRAM read/fill ports.
// On a miss it refills the block from instruction memory, then returns the
// requested 32-bit instruction word to the fetch stage.
//
// Optional feature macro: ICACHE_FWD_EN (critical-word forwarding)
//   defined   : the FILL cycle also returns the instruction from the refill
//               buffer, then the controller goes straight back to IDLE.
//   undefined : FILL -> REPLAY -> LOOKUP, and the instruction comes back
//               from the SRAM hit that follows.
//
// Ports
//   clk              : clock, all state changes on the rising edge
//   rst              : synchronous active-high reset
//   cpu_req          : fetch request valid
//   cpu_addr         : instruction byte address
//   cpu_ready        : request accepted on the edge where cpu_req && cpu_ready
//   cpu_valid        : cpu_instr valid, one pulse per accepted request
//   cpu_instr        : returned instruction word
//   sram_ren         : SRAM read enable
//   sram_wen         : SRAM fill write enable
//   sram_block_addr  : block address sent to the SRAM
//   sram_data_in     : fill block written into the SRAM
//   sram_hit         : SRAM hit, valid the cycle after sram_ren
//   sram_data_out    : SRAM read block, valid with sram_hit
//   mem_req          : refill request to instruction memory
//   mem_block_addr   : block address being refilled
//   mem_ack          : single-cycle refill acknowledge
//   mem_data         : refill block, valid with mem_ack
// ============================================================================
module icache_ctrl #(
    parameter  int ADDR_W       = 32,
    parameter  int WORD_W       = 32,
    parameter  int BLOCK_WORDS  = 4,
    localparam int OFS_W        = $clog2(BLOCK_WORDS * WORD_W / 8),
    localparam int BLOCK_ADDR_W = ADDR_W - OFS_W,
    localparam int BLOCK_BITS   = BLOCK_WORDS * WORD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    // CPU fetch side
    input  logic                    cpu_req,
    input  logic [ADDR_W-1:0]       cpu_addr,
    output logic                    cpu_ready,
    output logic                    cpu_valid,
    output logic [WORD_W-1:0]       cpu_instr,
    // SRAM array side
    output logic                    sram_ren,
    output logic                    sram_wen,
    output logic [BLOCK_ADDR_W-1:0] sram_block_addr,
    output logic [BLOCK_BITS-1:0]   sram_data_in,
    input  logic                    sram_hit,
    input  logic [BLOCK_BITS-1:0]   sram_data_out,
    // Instruction memory refill side
    output logic                    mem_req,
    output logic [BLOCK_ADDR_W-1:0] mem_block_addr,
    input  logic                    mem_ack,
    input  logic [BLOCK_BITS-1:0]   mem_data
);

    // Byte-within-word bits and word-within-block index width.
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int WIDX_W = $clog2(BLOCK_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        FILL,
        REPLAY
    } state_t;

    state_t                  state;
    state_t                  nstate;
    logic [ADDR_W-1:0]       req_addr;
    logic [BLOCK_BITS-1:0]   fill_buf;
    logic                    accept;

    logic [BLOCK_ADDR_W-1:0] req_blk;
    logic [WIDX_W-1:0]       req_widx;
    logic                    unused_byte_bits;

    always_comb begin
        req_blk          = req_addr[ADDR_W-1:OFS_W];
        req_widx         = req_addr[OFS_W-1:BYTE_W];
        // Byte offset within a word never selects anything.
        unused_byte_bits = ^req_addr[BYTE_W-1:0];
    end

    // ------------------------------------------------------------------
    // State and request/refill registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_addr <= '0;
            fill_buf <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                req_addr <= cpu_addr;
            end
            if (state == MISS && mem_ack) begin
                fill_buf <= mem_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // All outputs are forced low while rst is high, so an in-flight miss
    // or fill issues nothing further during the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        nstate          = state;
        accept          = 1'b0;
        cpu_ready       = 1'b0;
        cpu_valid       = 1'b0;
        cpu_instr       = '0;
        sram_ren        = 1'b0;
        sram_wen        = 1'b0;
        sram_block_addr = '0;
        sram_data_in    = '0;
        mem_req         = 1'b0;
        mem_block_addr  = '0;

        if (!rst) begin
            case (state)
                IDLE: begin
                    cpu_ready = 1'b1;
                end

                LOOKUP: begin
                    if (sram_hit) begin
                        cpu_valid = 1'b1;
                        cpu_instr = sram_data_out[req_widx * WORD_W +: WORD_W];
                        cpu_ready = 1'b1;
                        nstate    = IDLE;
                    end else begin
                        nstate = MISS;
                    end
                end

                MISS: begin
                    mem_req        = 1'b1;
                    mem_block_addr = req_blk;
                    if (mem_ack) begin
                        nstate = FILL;
                    end
                end

                FILL: begin
                    sram_wen        = 1'b1;
                    sram_block_addr = req_blk;
                    sram_data_in    = fill_buf;
`ifdef ICACHE_FWD_EN
                    cpu_valid = 1'b1;
                    cpu_instr = fill_buf[req_widx * WORD_W +: WORD_W];
                    nstate    = IDLE;
`else
                    nstate = REPLAY;
`endif
                end

                REPLAY: begin
                    sram_ren        = 1'b1;
                    sram_block_addr = req_blk;
                    nstate          = LOOKUP;
                end

                default: begin
                    nstate = IDLE;
                end
            endcase

            // Acceptance overrides the IDLE/LOOKUP-hit defaults above: the
            // new block is looked up in this same cycle (hit pipelining).
            if (cpu_ready && cpu_req) begin
                accept          = 1'b1;
                sram_ren        = 1'b1;
                sram_block_addr = cpu_addr[ADDR_W-1:OFS_W];
                nstate          = LOOKUP;
            end
        end
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Instruction-cache controller that sits directly upstream of the I-cache SRAM array. It accepts fetch requests from the CPU fetch stage and drives the SRAM read and fill ports (`ren`, `memWen`, `blockAddr`, `dataIn`). It consumes the SRAM `hit` and `dataOut` results, runs the miss/refill handshake with instruction memory, and returns the selected 32-bit instruction word to the fetch stage.

## Interface
Parameters:
- `ADDR_W`, 32, CPU byte-address width.
- `WORD_W`, 32, instruction word width.
- `BLOCK_WORDS`, 4, words per cache block (power of two, ≥2).
- Derived: `OFS_W = log2(BLOCK_WORDS*WORD_W/8)`, `BLOCK_ADDR_W = ADDR_W-OFS_W`, `BLOCK_BITS = BLOCK_WORDS*WORD_W`.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: fetch request valid.
- `cpu_addr` in ADDR_W: instruction byte address.
- `cpu_ready` out 1: a request is accepted on the edge where `cpu_req && cpu_ready`.
- `cpu_valid` out 1: `cpu_instr` is valid this cycle; one pulse per accepted request.
- `cpu_instr` out WORD_W: the returned instruction.
- `sram_ren` out 1: SRAM read enable.
- `sram_wen` out 1: SRAM fill write enable (memWen).
- `sram_block_addr` out BLOCK_ADDR_W: block address sent to the SRAM.
- `sram_data_in` out BLOCK_BITS: fill block.
- `sram_hit` in 1: SRAM hit result, valid the cycle after `sram_ren`.
- `sram_data_out` in BLOCK_BITS: SRAM read block, valid with `sram_hit`.
- `mem_req` out 1: refill request to instruction memory.
- `mem_block_addr` out BLOCK_ADDR_W: block address being refilled.
- `mem_ack` in 1: single-cycle acknowledge; `mem_data` is valid in the same cycle.
- `mem_data` in BLOCK_BITS: refill block.

## Operation
- States: IDLE, LOOKUP, MISS, FILL, REPLAY.
- Request acceptance:
  - `cpu_ready = !rst && (IDLE || (LOOKUP && sram_hit))`.
  - On acceptance, `sram_ren=1` and `sram_block_addr=cpu_addr[ADDR_W-1:OFS_W]` combinationally in that cycle.
  - The controller latches `cpu_addr` into `req_addr`, and the next state is LOOKUP.
- LOOKUP with `sram_hit=1`:
  - `cpu_valid=1` and `cpu_instr` = word `req_addr[OFS_W-1:2]` of `sram_data_out`.
  - Word 0 is bits `[WORD_W-1:0]`; address bits [1:0] are ignored.
  - If a new request is accepted in the same cycle, stay in LOOKUP. Otherwise go to IDLE.
- LOOKUP with `sram_hit=0`: next state is MISS.
- MISS:
  - `mem_req=1` and `mem_block_addr=req_addr` block bits, held stable until `mem_ack`.
  - On `mem_ack`, capture `mem_data` into `fill_buf`; the next state is FILL.
- FILL (one cycle):
  - `sram_wen=1`, with `sram_block_addr`/`sram_data_in` set from `req_addr`/`fill_buf`.
  - The next state depends on `ICACHE_FWD_EN` (see Configuration).
- REPLAY (one cycle): `sram_ren=1` with the `req_addr` block; the next state is LOOKUP, which is then guaranteed to hit.
- `sram_ren` and `sram_wen` are never high in the same cycle.
- Inputs are ignored outside the states that use them:
  - `sram_hit` and `sram_data_out` outside LOOKUP.
  - `mem_ack` outside MISS.

## Timing
- Reset values:
  - State is IDLE.
  - `cpu_ready=0` while `rst` is high.
  - `cpu_valid`, `sram_ren`, `sram_wen` and `mem_req` are 0.
  - `cpu_instr`, `sram_block_addr`, `sram_data_in`, `mem_block_addr` and `fill_buf` are all zeros.
- Hit latency: accept in cycle N, `cpu_valid` in cycle N+1. Back-to-back hits sustain one instruction per cycle.
- Miss, memory response: the miss is detected in cycle N+1, `mem_req` rises in N+2, and `mem_ack` arrives in cycle M.
- Miss, return to CPU:
  - With `ICACHE_FWD_EN`: `cpu_valid` in M+1.
  - Without it: `cpu_valid` in M+3.
- `mem_req` deasserts in the cycle after `mem_ack`. A `mem_ack` coinciding with the first MISS cycle is valid (zero-wait memory).
- Reset mid-operation:
  - Any state returns to IDLE on the next edge.
  - An outstanding miss is abandoned and `mem_req` is low after the edge.
  - A late `mem_ack` is ignored, and no SRAM write occurs.

## Configuration
- `ICACHE_FWD_EN` defined (critical-word forwarding):
  - In FILL, `cpu_valid=1` and `cpu_instr` is taken from `fill_buf` using the `req_addr` word index.
  - The next state is IDLE. REPLAY is unreachable.
- `ICACHE_FWD_EN` undefined:
  - FILL asserts no `cpu_valid`.
  - FILL → REPLAY → LOOKUP; the instruction is returned from the SRAM hit.

## Test plan
- Cold miss:
  - Stimulus: `cpu_addr=0x00000104`; `mem_ack` 3 cycles after `mem_req` with `mem_data={0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}`.
  - Required: `mem_block_addr=0x0000010`, a one-cycle `sram_wen` with the same block, then a single `cpu_valid` pulse with `cpu_instr=0xBBBB0001`.
  - Latency is M+1 with `ICACHE_FWD_EN` and M+3 without.
- Hit after fill: request `0x00000108` → `cpu_valid` exactly 1 cycle after acceptance, `cpu_instr=0xCCCC0002`, `mem_req` stays 0.
- Back-to-back hits:
  - Stimulus: `cpu_req` held high across `0x100`, `0x104`, `0x108`, `0x10C`.
  - Required: 4 consecutive `cpu_valid` cycles returning `0xAAAA0000`, `0xBBBB0001`, `0xCCCC0002`, `0xDDDD0003`, with `cpu_ready` high throughout.
- Stray acknowledge: `mem_ack=1` pulsed in IDLE and in LOOKUP → no state change, `sram_wen` stays 0, no extra `cpu_valid`.
- Reset mid-miss: `rst=1` for one cycle while in MISS, then a late `mem_ack` → IDLE, `mem_req=0`, no SRAM write, `cpu_ready=1` after reset deasserts.
